bp_be_stride_detector: RTL and testbench

//  Reference-prediction table that watches committed loads and detects constant positive strides per load PC.

---
 rtl/bp_be_stride_detector_pkg.sv | 28 ++
 rtl/bp_be_stride_detector_if.sv | 36 +++
 rtl/bp_be_stride_conf_ctr.sv | 24 ++
 rtl/bp_be_stride_detector.sv | 165 ++++++++++++++++
 tb/tb_bp_be_stride_detector.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_stride_detector_pkg.sv
// Shared types and helpers for the load stride detector.
//   bp_params_e    : processor configuration selector (supplies the virtual address width)
//   conf_op_e      : operation applied to an entry's 2-bit confidence counter
//   bp_vaddr_width : maps a configuration to its virtual address width
package bp_be_stride_detector_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  typedef enum logic [1:0] {
    e_conf_hold = 2'd0,
    e_conf_inc  = 2'd1,
    e_conf_dec  = 2'd2
  } conf_op_e;

  localparam logic [1:0] conf_max_lp = 2'd3;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 32'd39;
      e_bp_small_cfg:   return 32'd32;
      default:          return 32'd39;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_stride_detector_if.sv
// Prefetch request channel between the stride detector and the prefetch generator.
//   master : detector side, drives v_o and the request payload, samples ready_and_i
//   slave  : generator side, samples the request, drives ready_and_i
// A transfer happens on a clock edge where v_o & ready_and_i.
interface bp_be_stride_detector_if #(
  parameter int vaddr_width_p  = 39,
  parameter int stride_width_p = 8,
  parameter int loop_range_p   = 8
);

  logic                      v_o;
  logic                      ready_and_i;
  logic [vaddr_width_p-1:0]  pc_o;
  logic [vaddr_width_p-1:0]  eff_addr_o;
  logic [stride_width_p-1:0] stride_o;
  logic [loop_range_p-1:0]   loop_counter_o;

  modport master (
    output v_o,
    output pc_o,
    output eff_addr_o,
    output stride_o,
    output loop_counter_o,
    input  ready_and_i
  );

  modport slave (
    input  v_o,
    input  pc_o,
    input  eff_addr_o,
    input  stride_o,
    input  loop_counter_o,
    output ready_and_i
  );

endinterface

// File: rtl/bp_be_stride_conf_ctr.sv
// 2-bit saturating confidence counter update for one stride-table entry.
//   conf_i : current confidence
//   op_i   : hold / increment / decrement
//   conf_o : next confidence, saturating at 0 and 3
module bp_be_stride_conf_ctr
  import bp_be_stride_detector_pkg::*;
(
  input  logic [1:0] conf_i,
  input  conf_op_e   op_i,
  output logic [1:0] conf_o
);

  // Next confidence value with saturation at both ends
  always_comb begin
    conf_o = conf_i;
    case (op_i)
      e_conf_inc:  conf_o = (conf_i == conf_max_lp) ? conf_i : conf_i + 2'd1;
      e_conf_dec:  conf_o = (conf_i == 2'd0) ? conf_i : conf_i - 2'd1;
      e_conf_hold: conf_o = conf_i;
      default:     conf_o = conf_i;
    endcase
  end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Reference-prediction table that watches committed loads and detects constant
// positive strides per load PC, issuing one prefetch request per confident PC.
//   clk_i, reset_i         : clock, synchronous active-high reset
//   commit_v_i/pc/eaddr    : one committed load per cycle
//   pf_if (master)         : v_o/ready_and_i request channel with pc, eff_addr,
//                            stride and loop_counter payload (registered)
//   drop_o                 : registered pulse, high the cycle after a trigger that
//                            found the output slot full and not draining
module bp_be_stride_detector
  import bp_be_stride_detector_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int entries_p        = 16,
  parameter int stride_width_p   = 8,
  parameter int loop_range_p     = 8,
  parameter int prefetch_depth_p = 8,
  parameter int conf_thresh_p    = 2
)(
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         commit_v_i,
  input  logic [bp_vaddr_width(bp_params_p)-1:0]       commit_pc_i,
  input  logic [bp_vaddr_width(bp_params_p)-1:0]       commit_eaddr_i,
  bp_be_stride_detector_if.master                      pf_if,
  output logic                                         drop_o
);

  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p);
  localparam int lg_entries_lp = $clog2(entries_p);
  localparam logic [1:0] conf_thresh_lp = conf_thresh_p[1:0];
  localparam logic [loop_range_p-1:0] depth_lp = prefetch_depth_p[loop_range_p-1:0];

  typedef struct packed {
    logic                      v;
    logic [vaddr_width_p-1:0]  tag;
    logic [vaddr_width_p-1:0]  last_addr;
    logic [stride_width_p-1:0] stride;
    logic [1:0]                conf;
    logic [loop_range_p-1:0]   cooldown;
  } bp_be_stride_entry_s;

  bp_be_stride_entry_s table_r [entries_p];

  logic [lg_entries_lp-1:0]  idx_s;
  bp_be_stride_entry_s       entry_s;
  bp_be_stride_entry_s       entry_next_s;
  logic                      hit_s;
  logic [vaddr_width_p-1:0]  delta_s;
  logic                      legal_s;
  logic                      match_s;
  conf_op_e                  conf_op_s;
  logic [1:0]                conf_next_s;
  logic                      trigger_s;
  logic                      drain_s;
  logic                      load_s;
  logic                      drop_s;

  logic                      v_r;
  logic [vaddr_width_p-1:0]  pc_r;
  logic [vaddr_width_p-1:0]  eff_addr_r;
  logic [stride_width_p-1:0] stride_r;
  logic [loop_range_p-1:0]   loop_counter_r;
  logic                      drop_r;

  assign idx_s   = commit_pc_i[2 +: lg_entries_lp];
  assign entry_s = table_r[idx_s];
  assign hit_s   = commit_v_i & entry_s.v & (entry_s.tag == commit_pc_i);

  // Modular difference: a descending pattern wraps to a huge value and is rejected
  assign delta_s = commit_eaddr_i - entry_s.last_addr;
  assign legal_s = (delta_s != '0) & (delta_s[vaddr_width_p-1:stride_width_p] == '0);
  assign match_s = legal_s & (delta_s[stride_width_p-1:0] == entry_s.stride);

  assign conf_op_s = match_s ? e_conf_inc : e_conf_dec;

  bp_be_stride_conf_ctr conf_ctr (
    .conf_i (entry_s.conf),
    .op_i   (conf_op_s),
    .conf_o (conf_next_s)
  );

  assign trigger_s = hit_s & match_s & (conf_next_s >= conf_thresh_lp)
                   & (entry_s.cooldown == '0);

  // The slot can take a new request when empty or when its occupant leaves this cycle
  assign drain_s = v_r & pf_if.ready_and_i;
  assign load_s  = trigger_s & (~v_r | drain_s);
  assign drop_s  = trigger_s & v_r & ~drain_s;

  // Next contents of the indexed entry for a committed load (hit update or reallocation)
  always_comb begin
    entry_next_s = entry_s;
    if (hit_s) begin
      entry_next_s.last_addr = commit_eaddr_i;
      entry_next_s.conf      = conf_next_s;
      // Stride is only retrained once confidence has fully decayed
      if (~match_s && (entry_s.conf == 2'd0)) begin
        entry_next_s.stride = legal_s ? delta_s[stride_width_p-1:0] : '0;
      end else begin
        entry_next_s.stride = entry_s.stride;
      end
      // A dropped trigger leaves cooldown at zero so the next hit retries
      if (load_s) begin
        entry_next_s.cooldown = depth_lp;
      end else if (entry_s.cooldown != '0) begin
        entry_next_s.cooldown = entry_s.cooldown - {{(loop_range_p-1){1'b0}}, 1'b1};
      end else begin
        entry_next_s.cooldown = entry_s.cooldown;
      end
    end else begin
      entry_next_s.v         = 1'b1;
      entry_next_s.tag       = commit_pc_i;
      entry_next_s.last_addr = commit_eaddr_i;
      entry_next_s.stride    = '0;
      entry_next_s.conf      = 2'd0;
      entry_next_s.cooldown  = '0;
    end
  end

  // Reference-prediction table storage
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < entries_p; i++) begin
        table_r[i] <= '0;
      end
    end else if (commit_v_i) begin
      table_r[idx_s] <= entry_next_s;
    end else begin
      table_r[idx_s] <= table_r[idx_s];
    end
  end

  // One-entry output slot; a same-cycle transfer and trigger replaces the payload
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r            <= 1'b0;
      pc_r           <= '0;
      eff_addr_r     <= '0;
      stride_r       <= '0;
      loop_counter_r <= '0;
      drop_r         <= 1'b0;
    end else begin
      drop_r <= drop_s;
      if (load_s) begin
        v_r            <= 1'b1;
        pc_r           <= commit_pc_i;
        eff_addr_r     <= commit_eaddr_i;
        stride_r       <= delta_s[stride_width_p-1:0];
        loop_counter_r <= depth_lp;
      end else if (drain_s) begin
        v_r <= 1'b0;
      end else begin
        v_r <= v_r;
      end
    end
  end

  assign pf_if.v_o            = v_r;
  assign pf_if.pc_o           = pc_r;
  assign pf_if.eff_addr_o     = eff_addr_r;
  assign pf_if.stride_o       = stride_r;
  assign pf_if.loop_counter_o = loop_counter_r;
  assign drop_o               = drop_r;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Randomized and directed bench for bp_be_stride_detector against a per-PC
// behavioural model of the stride table and output slot.
module tb_bp_be_stride_detector;

  localparam int VA = 39;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          commit_v_i;
  logic [VA-1:0] commit_pc_i;
  logic [VA-1:0] commit_eaddr_i;
  logic          drop_o;

  bp_be_stride_detector_if #(.vaddr_width_p(VA), .stride_width_p(8), .loop_range_p(8)) pf_if ();

  bp_be_stride_detector dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .commit_v_i     (commit_v_i),
    .commit_pc_i    (commit_pc_i),
    .commit_eaddr_i (commit_eaddr_i),
    .pf_if          (pf_if),
    .drop_o         (drop_o)
  );

  always #5 clk_i = ~clk_i;

  int check_cnt = 0;
  int error_cnt = 0;

  // Model state: per-index table and expected output slot
  logic          m_v      [16];
  logic [VA-1:0] m_tag    [16];
  logic [VA-1:0] m_last   [16];
  logic [7:0]    m_stride [16];
  int            m_conf   [16];
  int            m_cd     [16];
  logic          exp_v, exp_drop;
  logic [VA-1:0] exp_pc, exp_ea;
  logic [7:0]    exp_stride, exp_lc;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic cv, input logic [VA-1:0] pc, input logic [VA-1:0] ea,
                              input logic rdy, input logic rst);
    int idx, nconf;
    logic trig, drain, legal, mt;
    logic [VA-1:0] delta;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_v[i] = 1'b0; m_tag[i] = '0; m_last[i] = '0; m_stride[i] = '0; m_conf[i] = 0; m_cd[i] = 0;
      end
      exp_v = 1'b0; exp_drop = 1'b0; exp_pc = '0; exp_ea = '0; exp_stride = '0; exp_lc = '0;
    end else begin
      drain = exp_v && rdy;
      trig  = 1'b0;
      idx   = int'(pc[5:2]);
      if (cv) begin
        if (!(m_v[idx] && m_tag[idx] == pc)) begin
          m_v[idx] = 1'b1; m_tag[idx] = pc; m_last[idx] = ea;
          m_stride[idx] = '0; m_conf[idx] = 0; m_cd[idx] = 0;
        end else begin
          delta = ea - m_last[idx];
          legal = (delta != 0) && (delta < 256);
          mt    = legal && (delta == {31'd0, m_stride[idx]});
          if (mt) nconf = (m_conf[idx] == 3) ? 3 : m_conf[idx] + 1;
          else begin
            nconf = (m_conf[idx] > 0) ? m_conf[idx] - 1 : 0;
            if (m_conf[idx] == 0) m_stride[idx] = legal ? delta[7:0] : 8'd0;
          end
          trig = mt && (nconf >= 2) && (m_cd[idx] == 0);
          m_conf[idx] = nconf;
          m_last[idx] = ea;
          if (m_cd[idx] > 0) m_cd[idx] = m_cd[idx] - 1;
          if (trig && (!exp_v || drain)) m_cd[idx] = 8;
        end
      end
      exp_drop = trig && exp_v && !drain;
      if (trig && (!exp_v || drain)) begin
        exp_v = 1'b1; exp_pc = pc; exp_ea = ea; exp_stride = m_stride[idx]; exp_lc = 8'd8;
      end else if (drain) begin
        exp_v = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs away from the edge, advance the model, compare after the edge
  task automatic step(input logic cv, input logic [VA-1:0] pc, input logic [VA-1:0] ea,
                      input logic rdy, input logic rst);
    @(negedge clk_i);
    commit_v_i = cv; commit_pc_i = pc; commit_eaddr_i = ea;
    pf_if.ready_and_i = rdy; reset_i = rst;
    model_update(cv, pc, ea, rdy, rst);
    @(posedge clk_i);
    #1;
    check_value("v_o", {63'd0, pf_if.v_o}, {63'd0, exp_v});
    check_value("drop_o", {63'd0, drop_o}, {63'd0, exp_drop});
    check_value("pc_o", {25'd0, pf_if.pc_o}, {25'd0, exp_pc});
    check_value("eff_addr_o", {25'd0, pf_if.eff_addr_o}, {25'd0, exp_ea});
    check_value("stride_o", {56'd0, pf_if.stride_o}, {56'd0, exp_stride});
    check_value("loop_counter_o", {56'd0, pf_if.loop_counter_o}, {56'd0, exp_lc});
  endtask

  localparam logic [VA-1:0] PC_A = 39'h0_8000_0100;
  localparam logic [VA-1:0] PC_B = 39'h0_8000_0200;
  localparam logic [VA-1:0] PC_C = 39'h0_8000_0140;

  logic [VA-1:0] r_pc   [6];
  logic [VA-1:0] r_next [6];
  logic [VA-1:0] r_str  [6];

  initial begin
    logic [VA-1:0] a, d;
    commit_v_i = 1'b0; commit_pc_i = '0; commit_eaddr_i = '0;
    pf_if.ready_and_i = 1'b0; reset_i = 1'b1;

    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check_value("rst_v", {63'd0, pf_if.v_o}, 64'd0);
    check_value("rst_lc", {56'd0, pf_if.loop_counter_o}, 64'd0);

    // 1: fourth commit with stride 0x40 triggers
    for (int i = 0; i < 4; i++) step(1'b1, PC_A, 39'h1000 + 39'(i * 'h40), 1'b0, 1'b0);
    check_value("t1_v", {63'd0, pf_if.v_o}, 64'd1);
    check_value("t1_pc", {25'd0, pf_if.pc_o}, 64'h8000_0100);
    check_value("t1_ea", {25'd0, pf_if.eff_addr_o}, 64'h10C0);
    check_value("t1_stride", {56'd0, pf_if.stride_o}, 64'h40);
    check_value("t1_lc", {56'd0, pf_if.loop_counter_o}, 64'd8);

    // 2: cooldown suppresses eight hits, the ninth retriggers
    for (int i = 0; i < 8; i++) step(1'b1, PC_A, 39'h1100 + 39'(i * 'h40), 1'b1, 1'b0);
    check_value("t2_cool", {63'd0, pf_if.v_o}, 64'd0);
    step(1'b1, PC_A, 39'h1300, 1'b0, 1'b0);
    check_value("t2_retrig", {63'd0, pf_if.v_o}, 64'd1);
    check_value("t2_ea", {25'd0, pf_if.eff_addr_o}, 64'h1300);

    // 3: second PC triggers into a full slot, then retries while draining
    for (int i = 0; i < 4; i++) step(1'b1, PC_B, 39'h5000 + 39'(i * 'h20), 1'b0, 1'b0);
    check_value("t3_drop", {63'd0, drop_o}, 64'd1);
    check_value("t3_keep", {25'd0, pf_if.pc_o}, 64'h8000_0100);
    step(1'b1, PC_B, 39'h5080, 1'b1, 1'b0);
    check_value("t3_v", {63'd0, pf_if.v_o}, 64'd1);
    check_value("t3_pc", {25'd0, pf_if.pc_o}, 64'h8000_0200);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // 4: illegal strides never trigger
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 39'h0_8000_0104, 39'h3000 + 39'(i * 'h100), 1'b1, 1'b0);
      step(1'b1, 39'h0_8000_0108, 39'h4000, 1'b1, 1'b0);
      step(1'b1, 39'h0_8000_010C, 39'h2000 - 39'(i * 'h40), 1'b1, 1'b0);
      check_value("t4_nov", {63'd0, pf_if.v_o}, 64'd0);
    end

    // 5: aliasing PCs keep evicting each other
    for (int i = 0; i < 8; i++) begin
      step(1'b1, PC_A, 39'h6000 + 39'(i * 'h40), 1'b1, 1'b0);
      step(1'b1, PC_C, 39'h7000 + 39'(i * 'h40), 1'b1, 1'b0);
      check_value("t5_nov", {63'd0, pf_if.v_o}, 64'd0);
    end

    // 6: reset with a pending request and saturated confidence
    for (int i = 0; i < 6; i++) step(1'b1, 39'h0_8000_0110, 39'h9000 + 39'(i * 'h10), 1'b0, 1'b0);
    check_value("t6_pend", {63'd0, pf_if.v_o}, 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check_value("t6_rst", {63'd0, pf_if.v_o}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 39'h0_8000_0110, 39'h9100 + 39'(i * 'h10), 1'b0, 1'b0);
      check_value("t6_wait", {63'd0, pf_if.v_o}, 64'd0);
    end
    step(1'b1, 39'h0_8000_0110, 39'h9130, 1'b0, 1'b0);
    check_value("t6_retrig", {63'd0, pf_if.v_o}, 64'd1);

    // Random mix of PCs, stride patterns, backpressure and occasional reset
    r_pc[0] = PC_A; r_pc[1] = 39'h0_8000_0104; r_pc[2] = 39'h0_8000_0108;
    r_pc[3] = PC_C; r_pc[4] = 39'h0_8000_0110; r_pc[5] = 39'h0_8000_013C;
    for (int k = 0; k < 6; k++) begin
      r_next[k] = 39'h10000 * 39'(k + 1);
      r_str[k]  = 39'($urandom_range(1, 255));
    end
    for (int n = 0; n < 2000; n++) begin
      int k, r;
      k = $urandom_range(0, 5);
      r = $urandom_range(0, 9);
      if (r < 6) d = r_str[k];
      else if (r == 6) begin r_str[k] = 39'($urandom_range(1, 255)); d = r_str[k]; end
      else if (r == 7) d = '0;
      else if (r == 8) d = 39'(256 + $urandom_range(0, 64));
      else d = -39'h40;
      a = r_next[k] + d;
      r_next[k] = a;
      step($urandom_range(0, 3) != 0, r_pc[k], a, $urandom_range(0, 2) != 0,
           $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
